// File: rtl/scene_cfg_pkg.sv
// Shared constants for the scene/config frame controller and its consumers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the frame geometry, the controller state encodings and the byte-index
// field map the renderer uses to locate values in the active bank.
// Optional build macro used by the controller: SCENE_CFG_CHECKSUM_EN.
package scene_cfg_pkg;

  localparam int NUM_BYTES = 55;
  localparam int IDX_W     = 6;

  // Typed copies so index comparisons stay width-matched.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [IDX_W-1:0] FULL_CNT = IDX_W'(NUM_BYTES);

  // Controller states.
  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_START   = 2'd2;

  // Byte-index field map of a frame, as seen through cfg_addr.
  localparam logic [IDX_W-1:0] FLD_SCENE_ID  = 6'd0;   // 1 byte
  localparam logic [IDX_W-1:0] FLD_FLAGS     = 6'd1;   // 1 byte
  localparam logic [IDX_W-1:0] FLD_BG_RGB    = 6'd2;   // 3 bytes
  localparam logic [IDX_W-1:0] FLD_CAM_POS   = 6'd5;   // 6 bytes, x/y/z 16-bit LE
  localparam logic [IDX_W-1:0] FLD_LIGHT     = 6'd11;  // 5 bytes
  localparam logic [IDX_W-1:0] FLD_OBJ_TABLE = 6'd16;  // 38 bytes
  localparam logic [IDX_W-1:0] FLD_CHECKSUM  = 6'd54;  // XOR of bytes 0..53 when checked

  // True when an index addresses a real byte of the frame.
  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return idx <= LAST_IDX;
  endfunction

endpackage

// File: rtl/cfg_bank_rf.sv
// Dual-bank NUM_BYTES x 8 register file: one synchronous write port, one async read port.
// Latency: write visible the cycle after the write edge; read is combinational.
// Backpressure: none; the write port always accepts.
//
// Ports: clk; wr_en/wr_bank/wr_addr/wr_data write the selected bank;
// rd_bank/rd_addr select the byte driven on rd_data. Out-of-range reads return 0,
// out-of-range writes are ignored. Contents are deliberately not reset.
module cfg_bank_rf
  import scene_cfg_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             rd_bank,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  logic [7:0] mem0 [NUM_BYTES];
  logic [7:0] mem1 [NUM_BYTES];

  always_ff @(posedge clk) begin
    if (wr_en && idx_in_range(wr_addr)) begin
      if (wr_bank) mem1[wr_addr] <= wr_data;
      else         mem0[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (idx_in_range(rd_addr)) begin
      rd_data = rd_bank ? mem1[rd_addr] : mem0[rd_addr];
    end
  end

endmodule

// File: rtl/scene_cfg_ctrl.sv
// Collects UART scene/config frames into a shadow bank, swaps banks in vblank, starts renderer.
// Latency: frame_done -> render_start >= 2 cycles (PENDING, swap edge, START).
// Backpressure: none upstream; bytes/frames arriving while a frame is pending are dropped and flagged.
//
// Ports: clk, reset (sync, active-high); byte_valid/byte_data/byte_idx and frame_done from
// the receiver; vblank and render_busy gate the swap; cfg_addr/cfg_data is the renderer's
// async view of the active bank; render_start, cfg_valid, active_bank, frame_count,
// overrun_err, seq_err report status. With SCENE_CFG_CHECKSUM_EN defined, byte 54 is
// an XOR checksum and chk_err reports frames dropped for a bad checksum.
module scene_cfg_ctrl
  import scene_cfg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  input  logic [IDX_W-1:0] byte_idx,
  input  logic             frame_done,
  input  logic             vblank,
  input  logic             render_busy,
  input  logic [IDX_W-1:0] cfg_addr,
  output logic [7:0]       cfg_data,
  output logic             render_start,
  output logic             cfg_valid,
  output logic             active_bank,
  output logic [7:0]       frame_count,
  output logic             overrun_err,
  output logic             seq_err
`ifdef SCENE_CFG_CHECKSUM_EN
  ,
  output logic             chk_err
`endif
);

  logic [1:0]       state, state_nx;
  logic [IDX_W-1:0] expected, exp_nx;
  logic             discard, disc_nx;
  logic             pend_byte, pend_byte_nx;  // a byte hit us while PENDING
  logic             wr_en;
  logic             seq_set;
  logic             ovr_set;
  logic             swap;
  logic             frame_ok;
`ifdef SCENE_CFG_CHECKSUM_EN
  logic [7:0]       chk, chk_nx;
  logic             chk_fail;
`endif

  cfg_bank_rf u_rf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_bank (~active_bank),
    .wr_addr (byte_idx),
    .wr_data (byte_data),
    .rd_bank (active_bank),
    .rd_addr (cfg_addr),
    .rd_data (cfg_data)
  );

  assign render_start = (state == ST_START);

  always_comb begin
    state_nx     = state;
    exp_nx       = expected;
    disc_nx      = discard;
    pend_byte_nx = pend_byte;
    wr_en        = 1'b0;
    seq_set      = 1'b0;
    ovr_set      = 1'b0;
    swap         = 1'b0;
    frame_ok     = 1'b0;
`ifdef SCENE_CFG_CHECKSUM_EN
    chk_nx       = chk;
    chk_fail     = 1'b0;
`endif
    case (state)
      ST_COLLECT: begin
        if (byte_valid) begin
          if (byte_idx == '0) begin
            // Index 0 always resynchronises, even mid-discard.
            wr_en   = 1'b1;
            disc_nx = 1'b0;
            exp_nx  = IDX_W'(1);
`ifdef SCENE_CFG_CHECKSUM_EN
            chk_nx  = byte_data;
`endif
          end else if (byte_idx == expected && idx_in_range(byte_idx)) begin
            // In-order byte of a frame already being discarded is silently ignored.
            if (!discard) begin
              wr_en  = 1'b1;
              exp_nx = expected + 1'b1;
`ifdef SCENE_CFG_CHECKSUM_EN
              chk_nx = chk ^ byte_data;
`endif
            end
          end else begin
            seq_set = 1'b1;
            disc_nx = 1'b1;
          end
        end
        // frame_done sees the effect of a byte accepted in the same cycle.
        if (frame_done) begin
          frame_ok = !disc_nx && (exp_nx == FULL_CNT);
`ifdef SCENE_CFG_CHECKSUM_EN
          if (frame_ok && chk_nx != 8'h00) begin
            chk_fail = 1'b1;
            frame_ok = 1'b0;
          end
`endif
          if (frame_ok) begin
            state_nx     = ST_PENDING;
            pend_byte_nx = 1'b0;
          end else begin
            disc_nx = 1'b0;
            exp_nx  = '0;
          end
        end
      end
      ST_PENDING: begin
        // Shadow holds a complete frame: nothing may be written until the swap.
        if (byte_valid || frame_done) ovr_set = 1'b1;
        if (byte_valid) pend_byte_nx = 1'b1;
        if (vblank && !render_busy) begin
          swap     = 1'b1;
          state_nx = ST_START;
        end
      end
      ST_START: begin
        // The frame whose bytes overran PENDING is incomplete: drop it up to the next index 0.
        state_nx = ST_COLLECT;
        exp_nx   = '0;
        disc_nx  = pend_byte;
      end
      default: begin
        state_nx = ST_COLLECT;
        exp_nx   = '0;
        disc_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_COLLECT;
      expected    <= '0;
      discard     <= 1'b0;
      pend_byte   <= 1'b0;
      active_bank <= 1'b0;
      frame_count <= 8'h00;
      cfg_valid   <= 1'b0;
      overrun_err <= 1'b0;
      seq_err     <= 1'b0;
`ifdef SCENE_CFG_CHECKSUM_EN
      chk         <= 8'h00;
      chk_err     <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      expected  <= exp_nx;
      discard   <= disc_nx;
      pend_byte <= pend_byte_nx;
      if (seq_set) seq_err     <= 1'b1;
      if (ovr_set) overrun_err <= 1'b1;
      if (swap) begin
        active_bank <= ~active_bank;
        frame_count <= frame_count + 8'd1;
        cfg_valid   <= 1'b1;
      end
`ifdef SCENE_CFG_CHECKSUM_EN
      chk <= chk_nx;
      if (chk_fail) chk_err <= 1'b1;
`endif
    end
  end

endmodule
